// File: rtl/mem_arbiter2.sv
// Two-port arbiter in front of a single-port synchronous RAM. Grants are combinational;
// read data returns one cycle after the grant on the port that issued the read.
module mem_arbiter2 #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIXED_PRI  = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              a_req,
  input  logic              a_rnw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_rnw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_cs,
  output logic              ram_rnw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic              last_b_q, last_b_d;
  logic [3:0]        starve_q, starve_d;
  logic [1:0]        rtag_q, rtag_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              b_win;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    b_win = 1'b0;
    if (resetb) begin
      if (a_req && b_req) begin
        if (FIXED_PRI != 0) b_win = (starve_q == StarveMax);
        else                b_win = !last_b_q;
        a_gnt = !b_win;
        b_gnt = b_win;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Address and write data hold their last granted values when idle.
  always_comb begin
    ram_rnw = 1'b1;
    addr_d  = addr_q;
    din_d   = din_q;
    if (a_gnt) begin
      ram_rnw = a_rnw;
      addr_d  = a_addr;
      din_d   = a_wdata;
    end else if (b_gnt) begin
      ram_rnw = b_rnw;
      addr_d  = b_addr;
      din_d   = b_wdata;
    end
  end

  assign ram_cs      = a_gnt | b_gnt;
  assign ram_address = addr_d;
  assign ram_din     = din_d;

  always_comb begin
    last_b_d = last_b_q;
    if (a_gnt) last_b_d = 1'b0;
    if (b_gnt) last_b_d = 1'b1;
    starve_d = starve_q;
    if (!b_req || b_gnt)          starve_d = 4'd0;
    else if (starve_q >= StarveMax) starve_d = StarveMax;
    else                          starve_d = starve_q + 4'd1;
    rtag_d = {b_gnt & b_rnw, a_gnt & a_rnw};
  end

  // Gating with resetb keeps a read issued just before reset from surfacing.
  assign a_rvalid = rtag_q[0] & resetb;
  assign b_rvalid = rtag_q[1] & resetb;
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      last_b_q <= 1'b1;
      starve_q <= 4'd0;
      rtag_q   <= 2'b00;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      last_b_q <= last_b_d;
      starve_q <= starve_d;
      rtag_q   <= rtag_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Bench for mem_arbiter2: round-robin and fixed-priority instances share stimulus, each with
// its own RAM and a cycle-level reference model; directed scenarios pin the model.
module tb_mem_arbiter2;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int SM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetb, a_req, a_rnw, b_req, b_rnw;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic [1:0] a_gnt, b_gnt, a_rvalid, b_rvalid, ram_cs, ram_rnw;
  logic [1:0][DW-1:0] a_rdata, b_rdata, ram_din, ram_dout;
  logic [1:0][AW-1:0] ram_address;

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0), .STARVE_MAX(SM)) u_rr (
    .clk(clk), .resetb(resetb),
    .a_req(a_req), .a_rnw(a_rnw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req), .b_rnw(b_rnw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .ram_cs(ram_cs[0]), .ram_rnw(ram_rnw[0]), .ram_address(ram_address[0]),
    .ram_din(ram_din[0]), .ram_dout(ram_dout[0])
  );

  mem_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1), .STARVE_MAX(SM)) u_fp (
    .clk(clk), .resetb(resetb),
    .a_req(a_req), .a_rnw(a_rnw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req), .b_rnw(b_rnw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .ram_cs(ram_cs[1]), .ram_rnw(ram_rnw[1]), .ram_address(ram_address[1]),
    .ram_din(ram_din[1]), .ram_dout(ram_dout[1])
  );

  // Environment RAMs: write-then-read ordering, read data valid the next cycle.
  logic [DW-1:0] ram_mem [2][4096];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_cs[i]) begin
        if (ram_rnw[i]) ram_dout[i] <= ram_mem[i][ram_address[i]];
        else            ram_mem[i][ram_address[i]] <= ram_din[i];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model state: who was granted last, how long B has waited, pending reads.
  int            m_last   [2];  // 0 = A, 1 = B
  int            m_starve [2];
  bit            m_pa     [2];
  bit            m_pb     [2];
  logic [DW-1:0] m_pd     [2];
  logic [DW-1:0] m_mem    [2][4096];

  task automatic model_step(input int i);
    logic ega, egb, bwin, ernw, eva, evb;
    string p;
    p = (i == 0) ? "rr" : "fp";
    ega = 1'b0;
    egb = 1'b0;
    if (resetb) begin
      if (a_req && b_req) begin
        bwin = (i == 1) ? (m_starve[i] == SM) : (m_last[i] == 0);
        ega  = !bwin;
        egb  = bwin;
      end else begin
        ega = a_req;
        egb = b_req;
      end
    end
    ernw = ega ? a_rnw : (egb ? b_rnw : 1'b1);
    eva  = resetb && m_pa[i];
    evb  = resetb && m_pb[i];
    check({p, ".a_gnt"}, 64'(a_gnt[i]), 64'(ega));
    check({p, ".b_gnt"}, 64'(b_gnt[i]), 64'(egb));
    check({p, ".ram_cs"}, 64'(ram_cs[i]), 64'(ega | egb));
    check({p, ".ram_rnw"}, 64'(ram_rnw[i]), 64'(ernw));
    if (ega) begin
      check({p, ".ram_address"}, 64'(ram_address[i]), 64'(a_addr));
      if (!a_rnw) check({p, ".ram_din"}, 64'(ram_din[i]), 64'(a_wdata));
    end
    if (egb) begin
      check({p, ".ram_address"}, 64'(ram_address[i]), 64'(b_addr));
      if (!b_rnw) check({p, ".ram_din"}, 64'(ram_din[i]), 64'(b_wdata));
    end
    check({p, ".a_rvalid"}, 64'(a_rvalid[i]), 64'(eva));
    check({p, ".b_rvalid"}, 64'(b_rvalid[i]), 64'(evb));
    if (eva) check({p, ".a_rdata"}, 64'(a_rdata[i]), 64'(m_pd[i]));
    if (evb) check({p, ".b_rdata"}, 64'(b_rdata[i]), 64'(m_pd[i]));
    // Advance to the state after the coming rising edge.
    if (!resetb) begin
      m_last[i]   = 1;
      m_starve[i] = 0;
      m_pa[i]     = 1'b0;
      m_pb[i]     = 1'b0;
    end else begin
      if (ega) m_last[i] = 0;
      if (egb) m_last[i] = 1;
      if (!b_req || egb) m_starve[i] = 0;
      else m_starve[i] = (m_starve[i] + 1 > SM) ? SM : m_starve[i] + 1;
      m_pa[i] = ega && a_rnw;
      m_pb[i] = egb && b_rnw;
      if (ega) begin
        if (a_rnw) m_pd[i] = m_mem[i][a_addr];
        else       m_mem[i][a_addr] = a_wdata;
      end
      if (egb) begin
        if (b_rnw) m_pd[i] = m_mem[i][b_addr];
        else       m_mem[i][b_addr] = b_wdata;
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  task automatic drive(input logic rb, input logic ar, input logic arnw,
                       input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic br, input logic brnw,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    resetb  = rb;
    a_req   = ar;
    a_rnw   = arnw;
    a_addr  = aa;
    a_wdata = ad;
    b_req   = br;
    b_rnw   = brnw;
    b_addr  = ba;
    b_wdata = bd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4096; j++) begin
        ram_mem[i][j] = '0;
        m_mem[i][j]   = '0;
      end
      m_last[i] = 1; m_starve[i] = 0; m_pa[i] = 1'b0; m_pb[i] = 1'b0; m_pd[i] = '0;
    end
    drive(1'b0, 1'b1, 1'b1, 12'h001, 32'h0, 1'b1, 1'b1, 12'h002, 32'h0);
    started = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset.ram_cs", 64'(ram_cs), 64'(2'b00));
      check("reset.ram_rnw", 64'(ram_rnw), 64'(2'b11));
      next_cycle();
    end

    // Both requesting from the first cycle out of reset.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b1, 12'h001, 32'h0, 1'b1, 1'b1, 12'h002, 32'h0);
      @(negedge clk);
      check("rr.pattern_a", 64'(a_gnt[0]), 64'(k % 2 == 0));
      check("rr.pattern_b", 64'(b_gnt[0]), 64'(k % 2 == 1));
      check("rr.pattern_cs", 64'(ram_cs[0]), 64'(1));
      check("fp.starve_a", 64'(a_gnt[1]), 64'(k != 4));
      check("fp.starve_b", 64'(b_gnt[1]), 64'(k == 4));
      next_cycle();
    end

    // Read latency on A.
    drive(1'b1, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 1'b1, 12'h0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 12'h010, 32'h0, 1'b0, 1'b1, 12'h0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1, 12'h0, 32'h0);
    @(negedge clk);
    check("rd.a_rvalid", 64'(a_rvalid), 64'(2'b11));
    check("rd.a_rdata0", 64'(a_rdata[0]), 64'h0000_0000_DEAD_BEEF);
    check("rd.a_rdata1", 64'(a_rdata[1]), 64'h0000_0000_DEAD_BEEF);
    check("rd.b_rvalid", 64'(b_rvalid), 64'(2'b00));
    next_cycle();
    @(negedge clk);
    check("rd.a_pulse_end", 64'(a_rvalid), 64'(2'b00));
    next_cycle();

    // Write then read on B to the top address.
    drive(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 1'b1, 1'b0, 12'hFFF, 32'h12345678);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 1'b1, 1'b1, 12'hFFF, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1, 12'h0, 32'h0);
    @(negedge clk);
    check("wr.b_rvalid", 64'(b_rvalid), 64'(2'b11));
    check("wr.b_rdata", 64'(b_rdata[0]), 64'h0000_0000_1234_5678);
    next_cycle();

    // Reset arriving right after a granted read.
    drive(1'b1, 1'b1, 1'b1, 12'h010, 32'h0, 1'b0, 1'b1, 12'h0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 12'h010, 32'h0, 1'b1, 1'b1, 12'h0, 32'h0);
    @(negedge clk);
    check("rst.a_rvalid", 64'(a_rvalid), 64'(2'b00));
    check("rst.ram_cs", 64'(ram_cs), 64'(2'b00));
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 12'h010, 32'h0, 1'b1, 1'b1, 12'h0, 32'h0);
    @(negedge clk);
    check("rst.a_first", 64'(a_gnt), 64'(2'b11));
    check("rst.no_rvalid", 64'({a_rvalid, b_rvalid}), 64'(0));
    next_cycle();

    // Idle.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
      @(negedge clk);
      check("idle.ram_cs", 64'(ram_cs), 64'(2'b00));
      check("idle.ram_rnw", 64'(ram_rnw), 64'(2'b11));
      next_cycle();
    end

    // Random traffic, mostly out of reset, on a small address set to force hazards.
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 63) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 7)), 32'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 7)), 32'($urandom));
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 12'h0, 32'h0, 1'b0, 1'b1, 12'h0, 32'h0);
    next_cycle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter2.md
MEM_ARBITER2 -- requirements
Module: mem_arbiter2

Interface
REQ-001 Parameter ADDR_W, default 12, is the RAM word-address width.
REQ-002 Parameter DATA_W, default 32, is the RAM data width.
REQ-003 Parameter FIXED_PRI, default 0, selects the arbitration mode: 0 is round-robin, 1 is port A fixed priority with a starvation guard.
REQ-004 Parameter STARVE_MAX, default 4, is the number of consecutive denied cycles on port B that forces a B grant in FIXED_PRI=1 mode; the legal range is 1..15.
REQ-005 The block SHALL have these ports (clock and reset first):
  clk  in  1  single clock; all state updates on the rising edge
  resetb  in  1  synchronous, active-low reset
  a_req  in  1  port A access request, held until granted
  a_rnw  in  1  port A access type: 1 = read, 0 = write
  a_addr  in  ADDR_W  port A word address
  a_wdata  in  DATA_W  port A write data
  a_gnt  out  1  port A request accepted this cycle
  a_rvalid  out  1  port A read data valid
  a_rdata  out  DATA_W  port A read data
  b_req, b_rnw, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
  ram_cs  out  1  RAM select, sampled by the RAM on the rising edge
  ram_rnw  out  1  RAM access type
  ram_address  out  ADDR_W  RAM word address
  ram_din  out  DATA_W  RAM write data
  ram_dout  in  DATA_W  RAM read data, valid the cycle after the access is issued

Function
REQ-006 ram_cs SHALL equal a_gnt OR b_gnt, combinationally; a_gnt and b_gnt SHALL never be high in the same cycle.
REQ-007 When a grant is issued, ram_rnw, ram_address and ram_din SHALL carry the granted port's rnw, addr and wdata in that same cycle.
REQ-008 With no grant, ram_rnw SHALL be 1; ram_address and ram_din hold their last driven values, which are don't-care.
REQ-009 A grant SHALL only be given to a port whose req is high in that cycle; the requester drops req or presents a new access on the cycle after gnt.
REQ-010 Round-robin mode (FIXED_PRI=0), single request: the requesting port is granted in the same cycle.
REQ-011 Round-robin mode, both ports requesting: the port not recorded in the last-grant register wins.
REQ-012 The last-grant register SHALL update on every issued grant.
REQ-013 Fixed mode (FIXED_PRI=1): A wins all conflicts unless the starvation counter equals STARVE_MAX, in which case B wins.
REQ-014 Fixed mode, starvation counter: 4 bits; increments when b_req is high and b_gnt is low; clears when b_gnt is high or b_req is low; saturates at STARVE_MAX.
REQ-015 Read return: a granted read in cycle N SHALL produce a one-cycle pulse on that port's rvalid in cycle N+1, with its rdata equal to ram_dout in cycle N+1.
REQ-016 Read-owner tracking SHALL be a registered 2-bit tag: bit 0 = read issued for A, bit 1 = read issued for B.
REQ-017 a_rdata and b_rdata SHALL both be driven from ram_dout at all times; only rvalid qualifies the data.
REQ-018 A granted write SHALL produce no rvalid.
REQ-019 Back-to-back grants in consecutive cycles SHALL be supported at full throughput (one access per cycle), including a read immediately following a write to the same address; the RAM's write-then-read ordering returns the new data.
REQ-020 Simultaneous events: a new grant in cycle N+1 alongside the rvalid of an access from cycle N is legal; both take effect.

Reset
REQ-021 While resetb=0 at a rising edge: last-grant register is set to B (so A wins the first conflict), starvation counter is set to 0, read tag is set to 00.
REQ-022 While resetb is low, a_gnt, b_gnt and ram_cs SHALL be forced to 0, and ram_rnw SHALL be forced to 1.
REQ-023 A read granted in the cycle before reset asserts SHALL produce no rvalid after reset.
REQ-024 After reset deasserts, the first grant is possible in the first cycle with resetb=1.

Verification
REQ-025 Round-robin: a_req=b_req=1 held for 4 cycles after reset -> grants A,B,A,B, with ram_cs=1 in every cycle.
REQ-026 Read latency: A reads addr 0x010 holding 0xDEADBEEF in cycle N -> a_rvalid=1 and a_rdata=0xDEADBEEF in cycle N+1 only; b_rvalid stays 0.
REQ-027 Write/read: B writes 0x12345678 to 0xFFF in cycle N, then B reads 0xFFF in cycle N+1 -> b_rvalid in cycle N+2 with 0x12345678.
REQ-028 Starvation: FIXED_PRI=1, STARVE_MAX=4, a_req and b_req held high -> A granted 4 cycles, B granted in cycle 5, then A again.
REQ-029 Reset mid-read: A read granted, resetb=0 on the next edge -> a_rvalid stays 0, ram_cs=0 while in reset, and with both requesting after release A wins first.
REQ-030 Idle: a_req=b_req=0 for 10 cycles -> ram_cs=0, ram_rnw=1, and no rvalid pulses.
